fmul_pipe: RTL and testbench
============================

Name: fmul_pipe

Overview:
- Pipelined single-precision floating-point multiplier for the FPU; the inverse operation to the divider.
- Accepts operand pairs through a valid/ready handshake and returns the product three clock cycles later.
- Flushes zero/subnormal inputs and results to signed zero, like the rest of the single-precision FPU.
- Rounds to nearest, ties to even, and saturates overflow to signed infinity.

Parameters:
none (format fixed: 1 sign, 8 exponent, 23 mantissa bits)

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  x1/x2 carry a valid operand pair
in_ready  output  1  block accepts a pair this cycle
x1  input  32  multiplicand {s,e,m}
x2  input  32  multiplier {s,e,m}
out_valid  output  1  y holds a valid product
out_ready  input  1  consumer accepts y this cycle
y  output  32  product {s,e,m}

Behaviour:
- Reset: one clock; rstn asynchronous, active-low.
  - Asserting rstn clears all three stage-valid bits immediately; out_valid=0, y=32'h0.
  - Datapath registers may be cleared or left as they are.
  - Reset mid-operation discards every in-flight pair; no output for them after release.
- Pipeline: three stages S1→S2→S3; S3 drives out_valid/y directly from registers.
  - Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv, combinational.
  - On adv, every stage loads from its predecessor; S1 loads in_valid & in_ready together with the operands.
  - When adv=0, all stages hold and y remains stable while out_valid=1.
- Latency and throughput:
  - A pair accepted at edge k appears at edge k+3 when no stall occurs.
  - One result per cycle in steady state.
  - Order is preserved.
- S1:
  - Unpack both operands.
  - Compute sy=s1^s2.
  - Form 24-bit significands {1,m}.
  - Compute partial products of the 24x24 multiply; the split is free, but S2 must hold the exact 48-bit P.
  - Compute special flags: z = (e1==0)|(e2==0); inf = ~z & ((e1==255)|(e2==255)).
  - Compute raw exponent E0 = e1+e2-127 as signed 10-bit.
- S2:
  - Sum the partial products to P[47:0].
  - Normalize: if P[47], mant=P[46:24], g=P[23], st=|P[22:0], E1=E0+1; else mant=P[45:23], g=P[22], st=|P[21:0], E1=E0.
- S3:
  - Round: up = g & (st | mant[0]); mant' = mant + up.
  - If mant' carries out of 23 bits, mant'=0 and E1 += 1.
  - Select output, in priority order:
    1. z → y={sy,8'h00,23'h0}.
    2. inf → y={sy,8'hFF,23'h0}.
    3. E1 ≥ 255 → y={sy,8'hFF,23'h0}.
    4. E1 ≤ 0 → y={sy,8'h00,23'h0}.
    5. Otherwise y={sy,E1[7:0],mant'}.
  - NaN is never generated. NaN inputs behave as infinity; zero×infinity gives zero.
- Simultaneous events:
  - out_ready=1 with out_valid=1 and in_valid=1: the output retires and a new pair is accepted in the same cycle.
  - Bubbles are not compressed; an empty S3 with out_ready=0 still advances.

Test Plan:
- Reset then no input → out_valid=0, y=0, in_ready=1. Drive x1=0x40000000, x2=0x40400000 at edge 0 with out_ready=1 → out_valid=1 at edge 3, y=0x40C00000.
- Back-to-back stream, out_ready=1, pairs (0x3FC00000,0x3FC00000), (0xC0000000,0x40400000), (0x3F800001,0x3F800001) → y=0x40100000, 0xC0C00000, 0x3F800002 on three consecutive cycles.
- Boundaries:
  - (0x7F000000,0x40000000) → 0x7F800000.
  - (0x00800000,0x3F000000) → 0x00000000.
  - (0x80000000,0x7F800000) → 0x80000000.
  - (0x3F800000,0x3F800000) → 0x3F800000.
- Backpressure: issue 4 pairs, hold out_ready=0 from edge 2.
  - in_ready=0 once S3 is full.
  - y stays constant while stalled.
  - Releasing out_ready drains all 4 results in order with no loss or duplication.
- Reset mid-flight: accept 2 pairs, pull rstn low asynchronously between edges → out_valid drops immediately, and no stale result appears after release.
- Random 10k normal-range pairs vs IEEE RNE reference model → bit-exact except flushed subnormal results.

Source files
------------

// File: rtl/fmul_pipe_if.sv
// Operand/result handshake bundle for the pipelined single-precision multiplier.
// The multiplier uses the slave modport; the producer/consumer side uses master.
interface fmul_pipe_if;
  localparam int unsigned W = 32;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/fmul_pipe.sv
// Three-stage single-precision multiplier: RNE rounding, zero/subnormal flush,
// overflow saturates to signed infinity, NaN inputs treated as infinity.
module fmul_pipe (
  input  logic       clk,
  input  logic       rstn,
  fmul_pipe_if.slave bus
);
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam int unsigned SW = MW + 1;
  localparam int unsigned HW = SW / 2;
  localparam int unsigned QW = SW + HW;
  localparam int unsigned PW = 2 * SW;
  localparam int unsigned XW = 10;
  localparam int unsigned BW = 32;

  localparam logic signed [XW-1:0] EMAX  = 10'sd255;
  localparam logic signed [XW-1:0] EZERO = 10'sd0;
  localparam logic        [XW-1:0] BIAS  = 10'd127;

  typedef struct packed {
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
  } fp_t;

  // Stage registers
  logic                 r_v1, r_v2, r_v3;
  logic                 r_sy1, r_sy2;
  logic                 r_z1, r_z2;
  logic                 r_inf1, r_inf2;
  logic signed [XW-1:0] r_e0, r_e1;
  logic [QW-1:0]        r_pp_lo, r_pp_hi;
  logic [MW-1:0]        r_mant;
  logic                 r_g, r_st;
  logic [BW-1:0]        r_y;

  logic w_adv;
  assign w_adv         = ~r_v3 | bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_v3;
  assign bus.y         = r_y;

  // S1: unpack, flags, raw exponent and two 24x12 partial products
  fp_t                  w_a, w_b;
  logic [SW-1:0]        w_sa, w_sb;
  logic [QW-1:0]        w_pp_lo, w_pp_hi;
  logic                 w_z1, w_inf1;
  logic signed [XW-1:0] w_e0;

  assign w_a     = fp_t'(bus.x1);
  assign w_b     = fp_t'(bus.x2);
  assign w_sa    = {1'b1, w_a.m};
  assign w_sb    = {1'b1, w_b.m};
  assign w_pp_lo = QW'(w_sa) * QW'(w_sb[HW-1:0]);
  assign w_pp_hi = QW'(w_sa) * QW'(w_sb[SW-1:HW]);
  assign w_z1    = (w_a.e == '0) | (w_b.e == '0);
  assign w_inf1  = ~w_z1 & ((&w_a.e) | (&w_b.e));
  assign w_e0    = $signed(XW'(w_a.e) + XW'(w_b.e) - BIAS);

  // S2: exact 48-bit product, normalize to 1.m with guard and sticky
  logic [PW-1:0]        w_p;
  logic [MW-1:0]        w_mant;
  logic                 w_g, w_st;
  logic signed [XW-1:0] w_e1;

  assign w_p = PW'(r_pp_lo) + (PW'(r_pp_hi) << HW);

  always_comb begin
    w_mant = w_p[PW-3:PW-2-MW];
    w_g    = w_p[PW-3-MW];
    w_st   = |w_p[PW-4-MW:0];
    w_e1   = r_e0;
    if (w_p[PW-1]) begin
      w_mant = w_p[PW-2:PW-1-MW];
      w_g    = w_p[PW-2-MW];
      w_st   = |w_p[PW-3-MW:0];
      w_e1   = r_e0 + 10'sd1;
    end
  end

  // S3: round to nearest even, then pick special / saturated / normal result
  logic                 w_up;
  logic [MW:0]          w_mr;
  logic signed [XW-1:0] w_e2;
  logic [BW-1:0]        w_y;

  assign w_up = r_g & (r_st | r_mant[0]);
  assign w_mr = {1'b0, r_mant} + (MW+1)'(w_up);
  assign w_e2 = r_e1 + $signed(XW'(w_mr[MW]));

  always_comb begin
    w_y = {r_sy2, w_e2[EW-1:0], w_mr[MW-1:0]};
    if (r_z2) begin
      w_y = {r_sy2, {EW{1'b0}}, {MW{1'b0}}};
    end else if (r_inf2) begin
      w_y = {r_sy2, {EW{1'b1}}, {MW{1'b0}}};
    end else if (w_e2 >= EMAX) begin
      w_y = {r_sy2, {EW{1'b1}}, {MW{1'b0}}};
    end else if (w_e2 <= EZERO) begin
      w_y = {r_sy2, {EW{1'b0}}, {MW{1'b0}}};
    end
  end

  // Whole pipe moves together; bubbles advance like data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_sy1   <= 1'b0;
      r_sy2   <= 1'b0;
      r_z1    <= 1'b0;
      r_z2    <= 1'b0;
      r_inf1  <= 1'b0;
      r_inf2  <= 1'b0;
      r_e0    <= '0;
      r_e1    <= '0;
      r_pp_lo <= '0;
      r_pp_hi <= '0;
      r_mant  <= '0;
      r_g     <= 1'b0;
      r_st    <= 1'b0;
      r_y     <= '0;
    end else if (w_adv) begin
      r_v1    <= bus.in_valid;
      r_sy1   <= w_a.s ^ w_b.s;
      r_z1    <= w_z1;
      r_inf1  <= w_inf1;
      r_e0    <= w_e0;
      r_pp_lo <= w_pp_lo;
      r_pp_hi <= w_pp_hi;
      r_v2    <= r_v1;
      r_sy2   <= r_sy1;
      r_z2    <= r_z1;
      r_inf2  <= r_inf1;
      r_e1    <= w_e1;
      r_mant  <= w_mant;
      r_g     <= w_g;
      r_st    <= w_st;
      r_v3    <= r_v2;
      r_y     <= w_y;
    end
  end
endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe: directed handshake/boundary cases plus a long random run
// scored against an arithmetic single-precision multiply model.
module tb_fmul_pipe;
  logic clk = 1'b0;
  logic rstn;

  fmul_pipe_if bus();

  fmul_pipe dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_acc  = 0;
  logic        hs_in      = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_y     = '0;
  logic [31:0] exp_q[$];
  logic [31:0] ret_y[$];
  int          ret_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Product from value arithmetic: exact integer product, locate leading one,
  // keep 24 significant bits and round the discarded remainder against one half.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic            s;
    int              ea, eb, e, n, sh;
    longint unsigned ma, mb, p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return {s, 31'h0};
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
    ma = 64'({1'b1, a[22:0]});
    mb = 64'({1'b1, b[22:0]});
    p  = ma * mb;
    n  = 0;
    for (int i = 0; i < 64; i++) if (p[i]) n = i;
    sh   = n - 23;
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    e = ea + eb - 127 + (n - 46);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 99);
    if (k < 3)       r[30:23] = 8'h00;
    else if (k < 6)  r[30:23] = 8'hFF;
    else if (k < 30) r[30:23] = 8'($urandom_range(1, 254));
    else             r[30:23] = 8'($urandom_range(64, 190));
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process: sampled mid-cycle, acts on the handshakes of the coming edge
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      prev_stall = 1'b0;
      hs_in      = 1'b0;
    end else begin
      check("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (prev_stall && bus.out_valid) check("y_hold", bus.y, prev_y);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got %h expected no output", bus.y);
        end else begin
          check("product", bus.y, exp_q.pop_front());
        end
        ret_y.push_back(bus.y);
        ret_c.push_back(cyc);
      end
      hs_in = bus.in_valid && bus.in_ready;
      if (hs_in) begin
        exp_q.push_back(ref_mul(bus.x1, bus.x2));
        n_acc++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_y     = bus.y;
    end
  end

  // Present a pair and hold it until the handshake edge has passed
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.x1       = a;
    bus.x2       = b;
    @(posedge clk); #1;
    while (!hs_in && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!hs_in) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ret(input int n);
    int t;
    t = 0;
    while (ret_y.size() < n && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (ret_y.size() < n) begin
      checks++;
      errors++;
      $display("FAIL ret_timeout: got %0d results expected %0d", ret_y.size(), n);
    end
  endtask

  task automatic clear_ret();
    ret_y.delete();
    ret_c.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_y;
    int          base;
    int          t;
    logic        seen;

    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x1        = '0;
    bus.x2        = '0;

    // Model pinned to hand-computed products
    check("model_2x3",      ref_mul(32'h40000000, 32'h40400000), 32'h40C00000);
    check("model_1p5sq",    ref_mul(32'h3FC00000, 32'h3FC00000), 32'h40100000);
    check("model_m2x3",     ref_mul(32'hC0000000, 32'h40400000), 32'hC0C00000);
    check("model_ulp",      ref_mul(32'h3F800001, 32'h3F800001), 32'h3F800002);
    check("model_ovf",      ref_mul(32'h7F000000, 32'h40000000), 32'h7F800000);
    check("model_unf",      ref_mul(32'h00800000, 32'h3F000000), 32'h00000000);
    check("model_zinf",     ref_mul(32'h80000000, 32'h7F800000), 32'h80000000);
    check("model_one",      ref_mul(32'h3F800000, 32'h3F800000), 32'h3F800000);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", bus.y, 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_y", bus.y, 32'h0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Latency: driven after edge 0, visible after edge 3
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x1        = 32'h40000000;
    bus.x2        = 32'h40400000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("lat_edge2_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge3_valid", 32'(bus.out_valid), 32'd1);
    check("lat_edge3_y", bus.y, 32'h40C00000);
    @(posedge clk); #1;
    clear_ret();

    // Back-to-back stream
    send(32'h3FC00000, 32'h3FC00000);
    send(32'hC0000000, 32'h40400000);
    send(32'h3F800001, 32'h3F800001);
    wait_ret(3);
    check("b2b_y0", ret_y[0], 32'h40100000);
    check("b2b_y1", ret_y[1], 32'hC0C00000);
    check("b2b_y2", ret_y[2], 32'h3F800002);
    check("b2b_gap01", 32'(ret_c[1] - ret_c[0]), 32'd1);
    check("b2b_gap12", 32'(ret_c[2] - ret_c[1]), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    clear_ret();

    // Boundaries
    send(32'h7F000000, 32'h40000000);
    send(32'h00800000, 32'h3F000000);
    send(32'h80000000, 32'h7F800000);
    send(32'h3F800000, 32'h3F800000);
    wait_ret(4);
    check("bnd_ovf",  ret_y[0], 32'h7F800000);
    check("bnd_unf",  ret_y[1], 32'h00000000);
    check("bnd_zinf", ret_y[2], 32'h80000000);
    check("bnd_one",  ret_y[3], 32'h3F800000);
    repeat (3) @(posedge clk);
    #1;
    clear_ret();

    // Backpressure from edge 2 while four pairs are issued
    fork
      begin
        send(32'h40000000, 32'h40400000);
        send(32'h3FC00000, 32'h3FC00000);
        send(32'hC0000000, 32'h40400000);
        send(32'h3F800000, 32'h3F800000);
      end
      begin
        @(posedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        held_y = bus.y;
        repeat (4) @(posedge clk);
        #1;
        check("bp_y_stable", bus.y, held_y);
        check("bp_in_ready_late", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
      end
    join
    wait_ret(4);
    repeat (6) @(posedge clk);
    #1;
    check("bp_count", 32'(ret_y.size()), 32'd4);
    check("bp_y0", ret_y[0], 32'h40C00000);
    check("bp_y1", ret_y[1], 32'h40100000);
    check("bp_y2", ret_y[2], 32'hC0C00000);
    check("bp_y3", ret_y[3], 32'h3F800000);
    clear_ret();

    // Asynchronous reset with two pairs in flight
    send(32'h40000000, 32'h40400000);
    send(32'h3FC00000, 32'h3FC00000);
    @(posedge clk); #1;
    check("mid_before_valid", 32'(bus.out_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid_async_valid", 32'(bus.out_valid), 32'd0);
    check("mid_async_y", bus.y, 32'h0);
    @(posedge clk);
    @(posedge clk); #3;
    rstn = 1'b1;
    clear_ret();
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("mid_no_stale_valid", 32'(seen), 32'd0);
    check("mid_no_stale_ret", 32'(ret_y.size()), 32'd0);

    // Random traffic with random backpressure
    base = n_acc;
    t    = 0;
    bus.in_valid = 1'b0;
    while ((n_acc - base) < 10000 && t < 60000) begin
      @(posedge clk); #1;
      t++;
      if (!bus.in_valid || hs_in) begin
        bus.in_valid = ($urandom_range(0, 4) != 0);
        bus.x1       = rand_op();
        bus.x2       = rand_op();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("rand_accepted", 32'(n_acc - base), 32'd10000);
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
